// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: STAGES carry-chain slices of WIDTH/STAGES bits, one register stage
// each, with a single global advance (valid/ready) and registered carry-out and signed overflow.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: illegal WIDTH/STAGES combination");
  end

  logic              adv_s;
  logic [STAGES-1:0] vld_r;
  logic [STAGES-1:0] cy_r;
  logic [WIDTH-1:0]  sum_r [STAGES];
  logic [WIDTH-1:0]  a_r   [STAGES];
  logic [WIDTH-1:0]  b_r   [STAGES];
  logic              ovf_r;

  logic [STAGES-1:0] src_v_s;
  logic [STAGES-1:0] src_c_s;
  logic [WIDTH-1:0]  src_a_s   [STAGES];
  logic [WIDTH-1:0]  src_b_s   [STAGES];
  logic [WIDTH-1:0]  src_sum_s [STAGES];
  logic [WIDTH-1:0]  nxt_sum_s [STAGES];
  logic [STAGES-1:0] nxt_c_s;
  logic [CHUNK:0]    part_s;
  logic              nxt_ovf_s;

  // Stage inputs: stage 0 takes the ports, stage k takes the registers of stage k-1.
  always_comb begin
    src_v_s = '0;
    src_c_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      src_a_s[k]   = '0;
      src_b_s[k]   = '0;
      src_sum_s[k] = '0;
    end
    src_v_s[0] = In_valid;
    src_c_s[0] = Cin;
    src_a_s[0] = A;
    src_b_s[0] = B;
    for (int k = 1; k < STAGES; k++) begin
      src_v_s[k]   = vld_r[k-1];
      src_c_s[k]   = cy_r[k-1];
      src_a_s[k]   = a_r[k-1];
      src_b_s[k]   = b_r[k-1];
      src_sum_s[k] = sum_r[k-1];
    end
  end

  // Per-stage chunk addition; the final stage also derives overflow from the carry into the MSB.
  always_comb begin
    part_s  = '0;
    nxt_c_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      nxt_sum_s[k] = src_sum_s[k];
      part_s = {1'b0, src_a_s[k][k*CHUNK +: CHUNK]} + {1'b0, src_b_s[k][k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, src_c_s[k]};
      nxt_sum_s[k][k*CHUNK +: CHUNK] = part_s[CHUNK-1:0];
      nxt_c_s[k] = part_s[CHUNK];
    end
    // sum bit = a ^ b ^ carry-in, so the carry into the MSB is recovered from the MSB sum bit.
    nxt_ovf_s = nxt_c_s[STAGES-1] ^ (src_a_s[STAGES-1][WIDTH-1] ^ src_b_s[STAGES-1][WIDTH-1]
                                     ^ nxt_sum_s[STAGES-1][WIDTH-1]);
  end

  // Stage registers: cleared by reset, all load together on advance, all hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= '0;
      cy_r  <= '0;
      ovf_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        sum_r[k] <= '0;
        a_r[k]   <= '0;
        b_r[k]   <= '0;
      end
    end else if (adv_s) begin
      vld_r <= src_v_s;
      cy_r  <= nxt_c_s;
      ovf_r <= nxt_ovf_s;
      for (int k = 0; k < STAGES; k++) begin
        sum_r[k] <= nxt_sum_s[k];
        a_r[k]   <= src_a_s[k];
        b_r[k]   <= src_b_s[k];
      end
    end
  end

  assign adv_s     = !vld_r[STAGES-1] || Out_ready;
  assign In_ready  = adv_s;
  assign Out_valid = vld_r[STAGES-1];
  assign Sum       = sum_r[STAGES-1];
  assign Cout      = cy_r[STAGES-1];
  assign Ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: five configurations share one stimulus stream, each with
// its own scoreboard; directed steps target the (8,2) instance, then a random sweep covers all.
module tb_pipelined_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        cin;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  int          n_cmp = 0;
  int          n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 5; g++) begin : g_cfg
    localparam int W = (g == 3) ? 16 : (g == 4) ? 32 : 8;
    localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 8 : 4;

    logic           in_ready;
    logic           out_valid;
    logic           cout;
    logic           ovf;
    logic [W-1:0]   sum;
    logic [W+1:0]   q_exp [$];
    int             q_tag [$];
    int             adv_cnt = 0;
    logic [W:0]     full;
    logic [W-1:0]   ms;
    logic           mo;
    logic [W+1:0]   exp_v;
    int             tag_v;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk      (clk),
      .rst      (rst),
      .In_valid (in_valid),
      .In_ready (in_ready),
      .A        (a[W-1:0]),
      .B        (b[W-1:0]),
      .Cin      (cin),
      .Out_valid(out_valid),
      .Out_ready(out_ready),
      .Sum      (sum),
      .Cout     (cout),
      .Ovf      (ovf)
    );

    // Scoreboard: pop/compare on output transfers, push model results on input transfers.
    always @(negedge clk) begin
      if (rst) begin
        q_exp.delete();
        q_tag.delete();
      end else begin
        if (out_valid === 1'b1 && out_ready) begin
          n_cmp++;
          assert (q_exp.size() != 0) else begin
            n_err++;
            $error("FAIL cfg%0d_unexpected: observed result %h expected no result", g, sum);
          end
          if (q_exp.size() != 0) begin
            exp_v = q_exp.pop_front();
            tag_v = q_tag.pop_front();
            n_cmp++;
            assert ({ovf, cout, sum} === exp_v) else begin
              n_err++;
              $error("FAIL cfg%0d_result: observed %h expected %h", g, {ovf, cout, sum}, exp_v);
            end
            n_cmp++;
            assert (adv_cnt - tag_v === S) else begin
              n_err++;
              $error("FAIL cfg%0d_latency: observed %0d expected %0d", g, adv_cnt - tag_v, S);
            end
          end
        end
        if (in_valid && in_ready === 1'b1) begin
          full = {1'b0, a[W-1:0]} + {1'b0, b[W-1:0]} + {{W{1'b0}}, cin};
          ms   = full[W-1:0];
          mo   = (a[W-1] == b[W-1]) && (ms[W-1] != a[W-1]);
          q_exp.push_back({mo, full[W], ms});
          q_tag.push_back(adv_cnt);
        end
        if (in_ready === 1'b1) adv_cnt++;
      end
    end
  end

  task automatic op_check(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, input logic [7:0] es, input logic ec, input logic eo);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    cin       = cv;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_early", tag), g_cfg[0].out_valid, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("%s_valid", tag), g_cfg[0].out_valid, 64'd1);
    chk($sformatf("%s_sum", tag), g_cfg[0].sum, es);
    chk($sformatf("%s_cout", tag), g_cfg[0].cout, ec);
    chk($sformatf("%s_ovf", tag), g_cfg[0].ovf, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic mv0, mv1, exp_rdy, acc;
    int   i, cyc, nres;

    rst = 1'b1; in_valid = 1'b1; a = 32'h55; b = 32'h66; cin = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", g_cfg[0].out_valid, 64'd0);
    chk("rst_sum", g_cfg[0].sum, 64'd0);
    chk("rst_cout", g_cfg[0].cout, 64'd0);
    chk("rst_ovf", g_cfg[0].ovf, 64'd0);
    chk("rst_in_ready", g_cfg[0].in_ready, 64'd1);
    @(posedge clk); #1;

    op_check("chunk_carry", 32'h0F, 32'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    op_check("ff_plus_1",   32'hFF, 32'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op_check("7f_cin",      32'h7F, 32'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    op_check("80_plus_80",  32'h80, 32'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Back-pressure: operand pairs (i, 2i), Out_ready pattern 1,0,0 repeating.
    mv0 = 1'b0; mv1 = 1'b0; i = 1; cyc = 0; nres = 0; cin = 1'b0;
    while ((i <= 5 || mv0 || mv1) && cyc < 60) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (i <= 5);
      a = 32'(i);
      b = 32'(2 * i);
      @(negedge clk);
      exp_rdy = !mv1 || out_ready;
      chk("bp_in_ready", g_cfg[0].in_ready, exp_rdy);
      chk("bp_out_valid", g_cfg[0].out_valid, mv1);
      if (mv1) begin
        chk("bp_sum", g_cfg[0].sum, 64'(3 * (nres + 1)));
        if (out_ready) nres++;
      end
      acc = in_valid && exp_rdy;
      @(posedge clk); #1;
      if (exp_rdy) begin
        mv1 = mv0;
        mv0 = acc;
      end
      if (acc) i++;
      cyc++;
    end
    chk("bp_result_count", nres, 64'd5);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Reset with two results in flight.
    in_valid = 1'b1; a = 32'h1; b = 32'h1;
    @(posedge clk); #1;
    a = 32'h2; b = 32'h2;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", g_cfg[0].out_valid, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_no_stale", g_cfg[0].out_valid, 64'd0);
    end
    @(posedge clk); #1;
    op_check("after_rst", 32'h20, 32'h22, 1'b0, 8'h42, 1'b0, 1'b0);

    // Random sweep across all configurations.
    for (int n = 0; n < 10000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a         = $urandom;
      b         = $urandom;
      cin       = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("drain_cfg0", g_cfg[0].q_exp.size(), 64'd0);
    chk("drain_cfg1", g_cfg[1].q_exp.size(), 64'd0);
    chk("drain_cfg2", g_cfg[2].q_exp.size(), 64'd0);
    chk("drain_cfg3", g_cfg[3].q_exp.size(), 64'd0);
    chk("drain_cfg4", g_cfg[4].q_exp.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder with a valid/ready handshake. It splits a WIDTH-bit addition into STAGES equal carry-chain slices, one slice per register stage, so wide sums close timing at the convolution datapath clock. It sits between the multiplier array and the output accumulator of the convolution core, and replaces fixed-width combinational adders wherever operands exceed 8 bits or a registered result is needed. It also reports carry-out and signed overflow.

## Interface
- WIDTH, 8: operand and sum width in bits; must be ≥ 2.
- STAGES, 2: number of pipeline stages. Must satisfy 1 ≤ STAGES ≤ WIDTH and WIDTH % STAGES == 0. CHUNK = WIDTH/STAGES bits are added per stage.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset: synchronous, active-high.
- In_valid  input  1  A, B and Cin are valid this cycle.
- In_ready  output  1  block accepts an operand set this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in to bit 0.
- Out_valid  output  1  Sum, Cout and Ovf are valid.
- Out_ready  input  1  downstream accepts the result this cycle.
- Sum  output  WIDTH  (A + B + Cin) mod 2^WIDTH.
- Cout  output  1  carry out of bit WIDTH-1.
- Ovf  output  1  two's-complement overflow: carry into the MSB XOR Cout.

## Operation
- Stage k (0..STAGES-1) adds bits [k·CHUNK +: CHUNK] of A, B using the carry registered by stage k-1. Stage 0 uses Cin.
- Each stage register holds:
  - a valid bit;
  - the chunk carry-out;
  - all sum chunks produced so far;
  - the not-yet-added upper operand chunks, delayed alongside.
- The last stage also registers the carry into the MSB, which is used for Ovf.
- All arithmetic is unsigned modulo 2^WIDTH. The Ovf flag is the only signed interpretation.
- Global advance: adv = !Out_valid || Out_ready.
  - When adv = 1, every stage register loads from its predecessor.
  - Stage 0 loads valid = In_valid.
  - When adv = 0, all stage registers hold, including payload.
- In_ready = adv, which is combinational from Out_valid and Out_ready.
- Transfers:
  - An input transfer occurs on a cycle with In_valid && In_ready.
  - An output transfer occurs on a cycle with Out_valid && Out_ready.
- Bubbles (invalid slots) travel through the pipeline. They are not collapsed.
- Payload registers of invalid slots may hold stale data. Outputs are defined only while Out_valid = 1.
- Order is strictly FIFO. No result is dropped or duplicated.
- STAGES = 1 degenerates to a single registered adder with the same handshake.

## Timing
- Reset, on a rising edge with rst = 1:
  - all stage valid bits go to 0, so Out_valid = 0;
  - Sum = 0, Cout = 0, Ovf = 0;
  - In_ready = 1 in the following cycle.
- rst takes priority over any simultaneous transfer. Reset mid-operation discards all in-flight results, and no partial result appears afterwards.
- Latency is exactly STAGES cycles from input transfer to Out_valid, when not stalled.
  - Example: inputs accepted at edge t give Out_valid = 1 after edge t + STAGES.
- Throughput is one result per cycle while Out_ready = 1.
- Stall: while Out_valid = 1 and Out_ready = 0:
  - In_ready = 0;
  - Sum, Cout and Ovf stay stable until the output transfer.
- Simultaneous pop and push in the same cycle: both complete and the pipeline advances one slot.
- Out_ready may be high while Out_valid = 0. The pipeline keeps advancing.

## Test plan
- Reset then idle, WIDTH=8, STAGES=2:
  - hold rst = 1 for 2 cycles with In_valid = 1;
  - require Out_valid = 0, Sum = 0x00 and In_ready = 1 after release.
- Single op, carry across the chunk boundary:
  - input A = 0x0F, B = 0x01, Cin = 0;
  - require Out_valid exactly 2 cycles later with Sum = 0x10, Cout = 0, Ovf = 0.
- Carry and overflow flags:
  - 0xFF + 0x01, Cin = 0 -> Sum = 0x00, Cout = 1, Ovf = 0;
  - 0x7F + 0x00, Cin = 1 -> Sum = 0x80, Cout = 0, Ovf = 1;
  - 0x80 + 0x80, Cin = 0 -> Sum = 0x00, Cout = 1, Ovf = 1.
- Back-pressure:
  - stream the 5 operand pairs (i, 2i) for i = 1..5 with Out_ready toggling 1,0,0,1,...;
  - require results 3, 6, 9, 12, 15 in order, none lost or duplicated;
  - require In_ready = 0 exactly on the stalled cycles, with Sum stable during each stall.
- Reset mid-stream:
  - assert rst with 2 results in flight;
  - require Out_valid = 0 on the next cycle and no stale result afterwards;
  - a new op 0x20 + 0x22 must produce 0x42.
- Parameter sweep, random:
  - configurations (WIDTH, STAGES) = (8,1), (8,8), (16,4), (32,4);
  - 10,000 random operands with random In_valid and Out_ready, checked against a reference model {Cout, Sum} = A + B + Cin;
  - require latency == STAGES on all unstalled transfers.
